// File: rtl/seq_divider.sv
// Sequential signed divider: one restoring-division step per clock.
// Operands are captured as magnitudes on the start edge. The quotient and
// remainder are re-signed when the result is published.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;
  logic             exc_flag;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             b_zero;
  logic             ovf_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign busy = (state == RUN);

  // Operand magnitudes and corner-case detection, valid on the start edge
  always_comb begin
    abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    b_zero = (data_operandB == '0);
    ovf_in = (data_operandA == MIN_NEG) && (data_operandB == '1);
  end

  // One restoring step: the shifted partial remainder is WIDTH+1 bits wide,
  // so a divisor magnitude of 2^(WIDTH-1) cannot overflow the trial subtract
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
  end

  // Control FSM, iteration datapath and result publication
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      divisor        <= '0;
      quo            <= '0;
      rem            <= '0;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      exc_flag       <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (state == DONE) begin
        data_result    <= neg_q ? -quo : quo;
        data_remainder <= neg_r ? -rem : rem;
        data_exception <= exc_flag;
        data_resultRDY <= 1'b1;
      end
      if (ctrl_div) begin
        divisor  <= abs_b;
        neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        neg_r    <= data_operandA[WIDTH-1];
        exc_flag <= b_zero | ovf_in;
        count    <= '0;
        if (b_zero) begin
          quo   <= '0;
          rem   <= abs_a;
          state <= DONE;
        end else begin
          quo   <= abs_a;
          rem   <= '0;
          state <= RUN;
        end
      end else begin
        case (state)
          RUN: begin
            if (!diff[WIDTH]) begin
              rem <= diff[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              rem <= shifted[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
            count <= count + 1'b1;
            if (count == LAST_ITER) begin
              state <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed operand pairs with hand-computed
// quotient, remainder, exception flag and result cycle.
module tb_seq_divider;

  logic        clock;
  logic        reset;
  logic        ctrl_div;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [31:0] rem;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Rising-edge counter used to timestamp result pulses
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clock) begin
    if (reset && busy) busy_cnt <= busy_cnt + 1;
    if (reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rdy: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", data_result, e.res);
        checkOutput("remainder", data_remainder, e.rem);
        checkOutput("exception", {31'd0, data_exception}, {31'd0, e.exc});
        checkOutput("rdy_cycle", cyc, e.cyc);
      end
    end
  end

  // Start an operation; the following rising edge is the start edge
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] er, input logic [31:0] erm,
                               input logic ee, input int lat, input bit expect_rdy);
    exp_t e;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_div      = 1'b1;
    if (expect_rdy) begin
      e.res = er;
      e.rem = erm;
      e.exc = ee;
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_div      = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h0000_0003;
  endtask

  // Bounded wait for the scoreboard to drain
  task automatic waitDone();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: %0d results outstanding expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int b0;
    reset         = 1'b0;
    ctrl_div      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    @(negedge clock);
    checkOutput("reset_result", data_result, 32'd0);
    checkOutput("reset_remainder", data_remainder, 32'd0);
    checkOutput("reset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    b0 = busy_cnt;
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    waitDone();
    checkOutput("busy_cycles_100_7", busy_cnt - b0, 32'd32);

    applyStimulus(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
    repeat (5) @(negedge clock);
    checkOutput("hold_result", data_result, 32'd14);
    checkOutput("hold_remainder", data_remainder, 32'd2);
    waitDone();

    applyStimulus(32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33, 1'b1);
    waitDone();
    applyStimulus(32'hFFFF_FFAF, 32'hFFFF_FFF7, 32'd9, 32'd0, 1'b0, 33, 1'b1);
    waitDone();

    b0 = busy_cnt;
    applyStimulus(32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1, 1'b1);
    waitDone();
    checkOutput("busy_cycles_div0", busy_cnt - b0, 32'd0);

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33, 1'b1);
    waitDone();
    applyStimulus(32'd7, 32'h8000_0000, 32'd0, 32'd7, 1'b0, 33, 1'b1);
    waitDone();

    // Restart: second start lands on E0+10, only its result may appear
    applyStimulus(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    repeat (8) @(negedge clock);
    applyStimulus(32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 33, 1'b1);
    waitDone();

    // Reset mid-operation at about E0+15
    applyStimulus(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    repeat (14) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("midreset_result", data_result, 32'd0);
    checkOutput("midreset_remainder", data_remainder, 32'd0);
    checkOutput("midreset_flags", {29'd0, data_exception, data_resultRDY, busy}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Start on the first rising edge after reset release
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #2 reset = 1'b1;
    applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b1);
    waitDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand and result width; only 32 is verified.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset asynchronous and active-low.
REQ-004 SHALL have port ctrl_div, input, 1, start pulse; operands are sampled on the edge where it is high.
REQ-005 SHALL have port data_operandA, input, WIDTH, signed two's-complement dividend.
REQ-006 SHALL have port data_operandB, input, WIDTH, signed two's-complement divisor.
REQ-007 SHALL have port data_result, output, WIDTH, signed quotient.
REQ-008 SHALL have port data_remainder, output, WIDTH, signed remainder.
REQ-009 SHALL have port data_exception, output, 1, divide-by-zero or overflow flag.
REQ-010 SHALL have port data_resultRDY, output, 1, one-cycle result-valid pulse.
REQ-011 SHALL have port busy, output, 1, high while in RUN.

Function
REQ-012 SHALL implement the states IDLE, RUN and DONE.
- IDLE -> RUN on ctrl_div.
- RUN -> DONE after 32 iterations.
- DONE -> IDLE after one cycle, or DONE -> RUN on ctrl_div.
REQ-013 SHALL honour ctrl_div in every state; in RUN it aborts the current operation and restarts with the newly sampled operands, and no RDY pulse is produced for the aborted operation.
REQ-014 SHALL capture the magnitudes |A| and |B| on the start edge, set the quotient sign to signA XOR signB and the remainder sign to signA, and clear the iteration counter to 0.
REQ-015 SHALL perform one restoring-division step per cycle in RUN: shift the 33-bit partial remainder left, bring in the next dividend bit (MSB first), and trial-subtract |B|.
- If the difference is non-negative, keep it and set the quotient bit to 1.
- Otherwise restore the partial remainder and set the quotient bit to 0.
REQ-016 SHALL use the 33-bit partial remainder so that |B| = 0x80000000 is handled without overflow.
REQ-017 SHALL truncate the quotient toward zero, with remainder = A - q*B and the remainder taking the sign of A.
REQ-018 SHALL apply latency from the start edge E0:
- iterations complete at edges E0+1 through E0+32;
- results are registered and data_resultRDY goes high after edge E0+33;
- data_resultRDY is cleared after E0+34.
REQ-019 SHALL detect B == 0 at the start edge and skip RUN:
- go to DONE at E0+1;
- set data_exception=1, data_result=0, data_remainder=A;
- pulse data_resultRDY during the cycle following E0+1.
REQ-020 SHALL handle A=0x80000000 with B=0xFFFFFFFF by running normally and producing data_result=0x80000000 (wrap), data_remainder=0, data_exception=1.
REQ-021 SHALL hold data_result, data_remainder and data_exception stable from the RDY pulse until the next RDY pulse; they are not cleared by a new start.
REQ-022 SHALL hold busy=1 exactly for the cycles in which the state is RUN.
REQ-023 SHALL ignore operand changes after the start edge.

Reset
REQ-024 SHALL, while reset=0, immediately force:
- state to IDLE;
- data_result, data_remainder and the counter to 0;
- data_exception, data_resultRDY and busy to 0.
REQ-025 SHALL abandon any in-flight operation on reset; after reset deasserts, no RDY pulse is emitted until a new ctrl_div is accepted.
REQ-026 SHALL accept ctrl_div on the first rising edge after reset deasserts.

Verification
REQ-027 SHALL cover positive division: A=100, B=7, ctrl_div at E0 -> RDY after E0+33, result=14, remainder=2, exception=0.
REQ-028 SHALL cover signed division: A=-100, B=7 -> result=0xFFFFFFF2, remainder=0xFFFFFFFE, exception=0; and A=100, B=-7 -> result=0xFFFFFFF2, remainder=2.
REQ-029 SHALL cover divide-by-zero: A=5, B=0 -> RDY after E0+1, exception=1, result=0, remainder=5, busy never high.
REQ-030 SHALL cover the overflow and large-divisor corners:
- A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, remainder=0, exception=1;
- A=7, B=0x80000000 -> result=0, remainder=7.
REQ-031 SHALL cover restart: start 100/7, then reassert ctrl_div with 81/9 at E0+10 -> exactly one RDY, 33 cycles after the second start, result=9, remainder=0.
REQ-032 SHALL cover reset mid-operation: assert reset at E0+15 -> all outputs 0 immediately, no RDY follows; a fresh 100/7 afterwards completes correctly.
